// File: rtl/vga_sink.sv
// vga_sink: samples a VGA/LCD stream, recovers pixel coordinates and checks frame geometry.
// Optional per-frame checksum accumulator is built when VGA_SINK_CHECKSUM_EN is defined.
module vga_sink #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        pix_clk,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_de,
  input  logic [4:0]  vga_r,
  input  logic [5:0]  vga_g,
  input  logic [4:0]  vga_b,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_sum,
  output logic [2:0]  err_flags
);

  typedef enum logic {SEEK = 1'b0, FRAME = 1'b1} state_t;

  localparam logic [10:0] H_EXP    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_EXP    = 10'(V_ACTIVE);
  localparam logic        SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    sat_inc11 = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic [15:0] rgb_q, rgb_d;
  logic [10:0] col_q, col_d;
  logic [9:0]  line_q, line_d;
  logic        bad_len_q, bad_len_d, dis_q, dis_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [15:0] pix_rgb_q, pix_rgb_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [2:0]  err_flags_q, err_flags_d;

  logic        vs_edge, de_rise, de_fall, in_frame, pixel, line_close;
  logic        line_len_bad, sync_hit;
  logic [10:0] cur_x;
  logic [9:0]  lines_closed;
  logic [2:0]  close_err;

  // Input capture with sync normalised to active-high, plus delayed copies for edge detection.
  always_comb begin
    hs_d      = vga_hsync ^ SYNC_INV;
    vs_d      = vga_vsync ^ SYNC_INV;
    de_d      = vga_de;
    rgb_d     = {vga_r, vga_g, vga_b};
    vs_prev_d = vs_q;
    de_prev_d = de_q;
  end

  assign vs_edge      = vs_q & ~vs_prev_q;
  assign de_rise      = de_q & ~de_prev_q;
  assign de_fall      = ~de_q & de_prev_q;
  assign in_frame     = (state_q == FRAME);
  assign pixel        = in_frame & de_q;
  assign line_close   = in_frame & de_fall;
  assign cur_x        = de_rise ? 11'd0 : col_q;
  assign line_len_bad = line_close & (col_q != H_EXP);
  assign sync_hit     = pixel & (hs_q | vs_q);
  // A line closing on the vsync-edge cycle still belongs to the frame being closed.
  assign lines_closed = line_close ? sat_inc10(line_q) : line_q;
  assign close_err    = {dis_q, (lines_closed != V_EXP), bad_len_q | line_len_bad};

  // State register.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state_q <= SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_q)
      SEEK:    state_d = vs_edge ? FRAME : SEEK;
      FRAME:   state_d = FRAME;
      default: state_d = SEEK;
    endcase
  end

  // Line/frame bookkeeping and output register inputs.
  always_comb begin
    col_d         = col_q;
    line_d        = line_q;
    bad_len_d     = bad_len_q;
    dis_d         = dis_q;
    pix_valid_d   = pixel;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    frame_lines_d = frame_lines_q;
    err_flags_d   = err_flags_q;
    case (state_q)
      SEEK: begin
        if (vs_edge) begin
          col_d     = 11'd0;
          line_d    = 10'd0;
          bad_len_d = 1'b0;
          dis_d     = 1'b0;
        end else begin
          col_d = col_q;
        end
      end
      FRAME: begin
        if (pixel) begin
          col_d     = sat_inc11(cur_x);
          pix_x_d   = cur_x;
          pix_y_d   = vs_edge ? 10'd0 : line_q;
          pix_rgb_d = rgb_q;
        end else begin
          col_d = col_q;
        end
        if (vs_edge) begin
          frame_done_d  = 1'b1;
          frame_lines_d = lines_closed;
          err_flags_d   = close_err;
          frame_ok_d    = (close_err == 3'b000);
          line_d        = 10'd0;
          bad_len_d     = 1'b0;
          dis_d         = sync_hit;
        end else begin
          line_d    = lines_closed;
          bad_len_d = bad_len_q | line_len_bad;
          dis_d     = dis_q | sync_hit;
        end
      end
      default: begin
        col_d     = 11'd0;
        line_d    = 10'd0;
        bad_len_d = 1'b0;
        dis_d     = 1'b0;
      end
    endcase
  end

  // Input, working and output registers.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      rgb_q         <= 16'h0000;
      col_q         <= 11'd0;
      line_q        <= 10'd0;
      bad_len_q     <= 1'b0;
      dis_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 11'd0;
      pix_y_q       <= 10'd0;
      pix_rgb_q     <= 16'h0000;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_lines_q <= 10'd0;
      err_flags_q   <= 3'b000;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      rgb_q         <= rgb_d;
      col_q         <= col_d;
      line_q        <= line_d;
      bad_len_q     <= bad_len_d;
      dis_q         <= dis_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      frame_lines_q <= frame_lines_d;
      err_flags_q   <= err_flags_d;
    end
  end

`ifdef VGA_SINK_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, frame_sum_q, frame_sum_d;

  // Pixels on the vsync-edge cycle seed the new frame's sum.
  always_comb begin
    sum_d       = sum_q;
    frame_sum_d = frame_sum_q;
    case (state_q)
      SEEK: begin
        if (vs_edge) begin
          sum_d = 16'h0000;
        end else begin
          sum_d = sum_q;
        end
      end
      FRAME: begin
        if (vs_edge) begin
          frame_sum_d = sum_q;
          sum_d       = pixel ? rgb_q : 16'h0000;
        end else if (pixel) begin
          sum_d = sum_q + rgb_q;
        end else begin
          sum_d = sum_q;
        end
      end
      default: sum_d = 16'h0000;
    endcase
  end

  // Checksum registers.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      sum_q       <= 16'h0000;
      frame_sum_q <= 16'h0000;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_lines = frame_lines_q;
  assign err_flags   = err_flags_q;

endmodule
